// File: rtl/dm_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_access_arbiter_if
// Request/acknowledge port used by each master of the data-memory arbiter
// (the CPU MEM stage and the external loader/debug/DMA port).
//   req    : request, held with its fields until ack
//   we     : 1 = write, 0 = read
//   be     : byte enables for writes (bit i -> bits [8i+7:8i])
//   addr   : byte address, bits [1:0] ignored
//   wdata  : write data, byte lanes already aligned
//   rdata  : read data, holds the last read value of this port
//   ack    : one-cycle completion pulse
// modport master : the requesting side
// modport slave  : the arbiter side
// -----------------------------------------------------------------------------
interface dm_access_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/dm_access_arbiter.sv
// -----------------------------------------------------------------------------
// dm_access_arbiter
// Shares the single port of the 4096-word data memory between the CPU MEM
// stage and an external master. Round-robin arbitration between the two
// request ports; byte-enabled writes are turned into a read-modify-write
// because the DM only accepts full-word writes.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low reset
//   cpu       : CPU request port (slave side of dm_access_arbiter_if)
//   ext       : external request port (slave side of dm_access_arbiter_if)
//   cpu_stall : cpu.req & ~cpu.ack, combinational, for the hazard unit
//   dm_we     : DM write enable
//   dm_addr   : word-aligned DM address
//   dm_wdata  : DM write data
//   dm_rdata  : DM combinational read data for dm_addr
//
// Command flow: IDLE (arbitrate + latch) -> ACCESS (read / full write /
// fetch old word for merge) -> [WRITE (merged word)] -> RESP (ack) -> IDLE.
// -----------------------------------------------------------------------------
module dm_access_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  dm_access_arbiter_if.slave   cpu,
  dm_access_arbiter_if.slave   ext,
  output logic                 cpu_stall,
  output logic                 dm_we,
  output logic [31:0]          dm_addr,
  output logic [31:0]          dm_wdata,
  input  logic [31:0]          dm_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  state_t      state_reg, state_next;

  // Priority pointer: port that wins when both request in the same cycle.
  logic        ptr_reg;

  // Latched command of the transaction in flight.
  logic        id_reg;
  logic        we_reg;
  logic [3:0]  be_reg;
  logic [31:2] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] merge_reg;

  // Per-port read data, held until that port's next read completes.
  logic [31:0] cpu_rdata_reg;
  logic [31:0] ext_rdata_reg;

  logic        any_req;
  logic        win_next;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:2] sel_addr;
  logic [31:0] sel_wdata;

  logic        be_full;
  logic        be_partial;
  logic [31:0] word_addr;
  logic [31:0] merged_word;
  logic        cpu_ack_int;
  logic        ext_ack_int;

  // Byte offset bits of the request addresses never reach the DM.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{cpu.addr[1:0], ext.addr[1:0]};

  // ---------------------------------------------------------------------------
  // Arbitration and request selection
  // ---------------------------------------------------------------------------
  assign any_req = cpu.req | ext.req;

  // With both requesting the pointer decides; otherwise the lone requester
  // wins (ext.req alone selects EXT, cpu.req alone leaves it at CPU).
  assign win_next = (cpu.req & ext.req) ? ptr_reg : ext.req;

  assign sel_we    = win_next ? ext.we          : cpu.we;
  assign sel_be    = win_next ? ext.be          : cpu.be;
  assign sel_addr  = win_next ? ext.addr[31:2]  : cpu.addr[31:2];
  assign sel_wdata = win_next ? ext.wdata       : cpu.wdata;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  assign be_full    = &be_reg;
  assign be_partial = (|be_reg) & ~be_full;

  // addr[ADDR_W-1:2] is the DM word index; the bits above it are passed
  // through unchanged so the full word-aligned address stays visible.
  assign word_addr = {addr_reg[31:ADDR_W], addr_reg[ADDR_W-1:2], 2'b00};

  // Read-modify-write merge: enabled lanes from the new data, the rest from
  // the word currently stored in the DM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8]
                                                 : dm_rdata[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // Only a partial write needs the extra cycle to store the merge.
        if (we_reg && be_partial) begin
          state_next = WRITE;
        end else begin
          state_next = RESP;
        end
      end
      WRITE: begin
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    dm_we       = 1'b0;
    dm_addr     = 32'h0;
    dm_wdata    = 32'h0;
    cpu_ack_int = 1'b0;
    ext_ack_int = 1'b0;
    case (state_reg)
      ACCESS: begin
        dm_addr = word_addr;
        if (we_reg && be_full) begin
          dm_we    = 1'b1;
          dm_wdata = wdata_reg;
        end
      end
      WRITE: begin
        dm_we    = 1'b1;
        dm_addr  = word_addr;
        dm_wdata = merge_reg;
      end
      RESP: begin
        cpu_ack_int = (id_reg == PORT_CPU);
        ext_ack_int = (id_reg == PORT_EXT);
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg       <= PORT_CPU;
      id_reg        <= PORT_CPU;
      we_reg        <= 1'b0;
      be_reg        <= 4'h0;
      addr_reg      <= '0;
      wdata_reg     <= 32'h0;
      merge_reg     <= 32'h0;
      cpu_rdata_reg <= 32'h0;
      ext_rdata_reg <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            id_reg    <= win_next;
            we_reg    <= sel_we;
            be_reg    <= sel_be;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
          end
        end
        ACCESS: begin
          if (!we_reg) begin
            if (id_reg == PORT_EXT) begin
              ext_rdata_reg <= dm_rdata;
            end else begin
              cpu_rdata_reg <= dm_rdata;
            end
          end else if (be_partial) begin
            merge_reg <= merged_word;
          end
        end
        RESP: begin
          // The port just served yields priority to the other one.
          ptr_reg <= ~id_reg;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Port outputs
  // ---------------------------------------------------------------------------
  assign cpu.ack   = cpu_ack_int;
  assign ext.ack   = ext_ack_int;
  assign cpu.rdata = cpu_rdata_reg;
  assign ext.rdata = ext_rdata_reg;
  assign cpu_stall = cpu.req & ~cpu_ack_int;

endmodule
